beam_output_formatter: RTL and testbench
========================================

# beam_output_formatter

Downstream stage of the beamformer core. Accepts the full-precision complex beam sample stream (valid/ready) and rounds, scales and saturates each component to `OUT_WIDTH`. It buffers the results in a small FIFO and emits a packed {Q,I} stream with a frame-boundary marker for the transport/DMA stage. The core's output register is decoupled from transport backpressure through `beam_ready_o`.

## Interface
Parameters:
- `ACC_WIDTH`, default `` `ACC_WIDTH ``: width of the incoming signed beam components.
- `OUT_WIDTH`, default 16: width of each signed output component.
- `SHIFT`, default 8: arithmetic right shift applied before saturation. Range is 1 to ACC_WIDTH-1.
- `FIFO_DEPTH`, default 8: output FIFO entries. Must be a power of 2 and at least 4.
- `FRAME_LEN`, default 256: samples per frame. `m_tlast` marks the last sample of each frame.

Ports (clock and reset first):
- `core_clk`, in, 1: the single clock.
- `core_rst_n`, in, 1: reset, synchronous and active-low.
- `beam_real_i`, in, ACC_WIDTH: signed real component.
- `beam_imag_i`, in, ACC_WIDTH: signed imaginary component.
- `beam_valid_i`, in, 1: input sample valid.
- `beam_ready_o`, out, 1: formatter can accept a sample.
- `flush_i`, in, 1: synchronous flush of the pipeline, FIFO and frame counter.
- `m_tdata`, out, 2*OUT_WIDTH: {Q[OUT_WIDTH-1:0], I[OUT_WIDTH-1:0]}.
- `m_tvalid`, out, 1: output valid.
- `m_tready`, in, 1: output ready.
- `m_tlast`, out, 1: last sample of frame.
- `status_o`, out, 32: {sat_count[15:0], 4'h0, fifo_level[3:0], frame_idx[7:0]}. frame_idx holds the low 8 bits.

## Operation
- Input handshake: a sample is accepted when `beam_valid_i && beam_ready_o`.
- `beam_ready_o = (fifo_count + s1_valid) < FIFO_DEPTH`. It counts the sample in flight, so the FIFO never overflows. It is registered-free combinational from internal registers only, never from `m_tready`.
- Stage 1 (register) applies to each component independently:
  - Compute t = x + 2^(SHIFT-1) at ACC_WIDTH+1 bits.
  - Compute y = t >>> SHIFT.
  - Clamp y to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Rounding is round-half-up toward +inf.
- Stage 2 is a FIFO of {Q,I} words. Stage 1 pushes one word per cycle when it is valid. The FIFO pops when `m_tvalid && m_tready`.
- Output: `m_tvalid` = FIFO non-empty. `m_tdata` is the head word, driven first-word-fall-through from the head register.
- `m_tdata`/`m_tlast` are held stable while `m_tvalid && !m_tready`.
- Frame counter frame_idx (0 to FRAME_LEN-1):
  - It increments on each output handshake and wraps to 0 after FRAME_LEN-1.
  - `m_tlast = m_tvalid && (frame_idx == FRAME_LEN-1)`.
- Simultaneous push and pop on a full or empty FIFO: the count is unchanged and ordering is preserved. A push into an empty FIFO with a pop in the same cycle is impossible, because the head is not yet valid.
- `flush_i`: takes priority over all handshakes in that cycle. It clears s1_valid, the FIFO pointers/count and frame_idx. The sample offered on the input in that cycle is dropped, and `beam_ready_o` is low that cycle.
- A sat_count flush is not performed. sat_count is cleared only by reset.

## Timing
- Latency: input accepted at cycle N gives `m_tvalid` high at N+2, provided the FIFO was empty.
- Throughput: 1 sample per cycle while `m_tready` is held high.
- Reset (`core_rst_n` low at a `core_clk` edge) sets `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `status_o`=0 and `beam_ready_o`=0 during reset. After release, `beam_ready_o`=1 in the first cycle.
- Reset mid-frame discards all buffered samples. The next output starts at frame_idx 0.

## Configuration
- Macro: `BEAM_OUT_SAT_CNT_EN`.
- Defined:
  - A 16-bit saturation counter increments by the number of clamped components (0, 1 or 2) per stage-1 sample.
  - The counter sticks at 0xFFFF.
  - It appears in `status_o[31:16]`.
- Undefined: no counter logic is built, and `status_o[31:16]` is tied to 0. The datapath is identical in both cases.

## Structure
- Shared package/defines (`beamformer_defines.vh`): `BEAM_OUT_WIDTH`, `BEAM_OUT_SHIFT` and `BEAM_FRAME_LEN` defaults, plus the status field offsets.
- One sub-module: `beam_out_fifo`, a synchronous FWFT FIFO with count output, parameterised by width and depth.
- Round and saturate logic is a local function used for both components.

## Test plan
- Rounding, with SHIFT=8 and OUT_WIDTH=16:
  - Input I=384, Q=-384 gives m_tdata {Q=0xFFFF (-1), I=0x0002}.
  - I=127 gives 0.
  - I=128 gives 1.
- Saturation: I=2^23, Q=-2^24 gives I=0x7FFF, Q=0x8000. With the macro defined, sat_count=2.
- Backpressure: stream 20 samples with `m_tready`=0.
  - `beam_ready_o` drops after 8 accepts (FIFO_DEPTH=8).
  - Raise `m_tready`. All 20 samples emerge in order with no loss.
- Frame marker: with FRAME_LEN=4, 10 continuous samples give `m_tlast` on outputs 3 and 7. frame_idx ends at 2.
- Flush and reset:
  - Assert `flush_i` with 5 words buffered. Next cycle `m_tvalid`=0 and frame_idx=0.
  - Assert `core_rst_n` low mid-stream. All outputs are 0, and `status_o`=0.

Source files
------------

// File: rtl/beam_output_formatter_pkg.sv
// Shared definitions for the beam output formatter.
//   - Default widths and sizes used by the formatter and its interface.
//   - Bit offsets of the fields inside the 32-bit status word.
//   - sat_add16: adds a small increment to a 16-bit counter and holds it at 0xFFFF.
package beam_output_formatter_pkg;

    localparam int BEAM_ACC_WIDTH  = 32;
    localparam int BEAM_OUT_WIDTH  = 16;
    localparam int BEAM_OUT_SHIFT  = 8;
    localparam int BEAM_FIFO_DEPTH = 8;
    localparam int BEAM_FRAME_LEN  = 256;

    // Status word layout: {sat_count[15:0], 4'h0, fifo_level[3:0], frame_idx[7:0]}
    localparam int ST_FRAME_LSB = 0;
    localparam int ST_LEVEL_LSB = 8;
    localparam int ST_SAT_LSB   = 16;

    function automatic logic [15:0] sat_add16(input logic [15:0] acc, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, acc} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/beam_output_formatter_if.sv
// Packed {Q,I} output stream of the beam output formatter.
//   m_tdata  : {Q[OUT_WIDTH-1:0], I[OUT_WIDTH-1:0]} head word
//   m_tvalid : head word valid
//   m_tready : downstream accepts the head word
//   m_tlast  : head word is the last sample of a frame
// The master modport is used by the formatter. The slave modport is used by the transport stage.
interface beam_output_formatter_if
    import beam_output_formatter_pkg::*;
#(
    parameter int OUT_WIDTH = BEAM_OUT_WIDTH
);
    logic [2*OUT_WIDTH-1:0] m_tdata;
    logic                   m_tvalid;
    logic                   m_tready;
    logic                   m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/beam_out_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   flush_i        : clears the pointers and the count. It wins over push and pop.
//   push_i/wdata_i : write one word
//   pop_i          : discard the head word
//   rdata_o        : head word, valid whenever valid_o is high
//   valid_o        : FIFO non-empty
//   count_o        : number of stored words (0..DEPTH)
module beam_out_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
endmodule

// File: rtl/beam_output_formatter.sv
// Beam output formatter. It rounds, scales and saturates complex beam samples to OUT_WIDTH,
// buffers them in a FWFT FIFO and emits a packed {Q,I} stream with a frame marker.
//   core_clk, core_rst_n : clock, synchronous active-low reset
//   beam_real_i/imag_i   : signed ACC_WIDTH input components
//   beam_valid_i/ready_o : input handshake. ready never depends on m_tready.
//   flush_i              : drops stage 1, the FIFO contents and the frame position
//   m_axis               : output stream (m_tdata/m_tvalid/m_tready/m_tlast)
//   status_o             : {sat_count, 4'h0, fifo_level[3:0], frame_idx[7:0]}
// Optional feature: define BEAM_OUT_SAT_CNT_EN to build the 16-bit sticky saturation counter.
// Without it, status_o[31:16] reads 0.
module beam_output_formatter
    import beam_output_formatter_pkg::*;
#(
    parameter int ACC_WIDTH  = BEAM_ACC_WIDTH,
    parameter int OUT_WIDTH  = BEAM_OUT_WIDTH,
    parameter int SHIFT      = BEAM_OUT_SHIFT,
    parameter int FIFO_DEPTH = BEAM_FIFO_DEPTH,
    parameter int FRAME_LEN  = BEAM_FRAME_LEN
) (
    input  logic                        core_clk,
    input  logic                        core_rst_n,
    input  logic signed [ACC_WIDTH-1:0] beam_real_i,
    input  logic signed [ACC_WIDTH-1:0] beam_imag_i,
    input  logic                        beam_valid_i,
    output logic                        beam_ready_o,
    input  logic                        flush_i,
    beam_output_formatter_if.master     m_axis,
    output logic [31:0]                 status_o
);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int FRAME_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic signed [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} <<< (SHIFT - 1);
    localparam logic signed [ACC_WIDTH:0] MAXV = {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] MINV = ~MAXV;

    // Returns {saturated, value}. One extra bit of headroom keeps x + HALF from wrapping.
    function automatic logic [OUT_WIDTH:0] round_sat(input logic signed [ACC_WIDTH-1:0] x);
        logic signed [ACC_WIDTH:0] t;
        logic signed [ACC_WIDTH:0] y;
        t = $signed({x[ACC_WIDTH-1], x}) + HALF;
        y = t >>> SHIFT;
        if (y > MAXV)      round_sat = {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
        else if (y < MINV) round_sat = {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
        else               round_sat = {1'b0, y[OUT_WIDTH-1:0]};
    endfunction

    logic [OUT_WIDTH:0]     re_rs, im_rs;
    logic                   accept;
    logic                   s1_valid_q, s1_valid_d;
    logic [2*OUT_WIDTH-1:0] s1_data_q, s1_data_d;
    logic [2*OUT_WIDTH-1:0] head_data;
    logic                   head_valid;
    logic [CNT_W-1:0]       fifo_count;
    logic                   pop;
    logic [FRAME_W-1:0]     frame_idx_q, frame_idx_d;
    logic                   frame_end;
    logic [15:0]            sat_field;

    always_comb begin
        re_rs = round_sat(beam_real_i);
        im_rs = round_sat(beam_imag_i);
    end

    // The word held in stage 1 is counted so that it always has a FIFO slot when it lands.
    assign beam_ready_o = core_rst_n && !flush_i &&
                          (({1'b0, fifo_count} + (CNT_W+1)'(s1_valid_q)) < (CNT_W+1)'(FIFO_DEPTH));
    assign accept = beam_valid_i && beam_ready_o;

    // Stage 1: rounded and saturated {Q,I} word
    always_comb begin
        s1_valid_d = accept;
        s1_data_d  = accept ? {im_rs[OUT_WIDTH-1:0], re_rs[OUT_WIDTH-1:0]} : s1_data_q;
    end

    always_ff @(posedge core_clk) begin
        if (!core_rst_n) s1_valid_q <= 1'b0;
        else             s1_valid_q <= s1_valid_d;
    end

    always_ff @(posedge core_clk) begin
        s1_data_q <= s1_data_d;
    end

    // Stage 2: FWFT output buffer
    beam_out_fifo #(
        .WIDTH (2*OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (core_clk),
        .rst_n_i (core_rst_n),
        .flush_i (flush_i),
        .push_i  (s1_valid_q && !flush_i),
        .wdata_i (s1_data_q),
        .pop_i   (pop),
        .rdata_o (head_data),
        .valid_o (head_valid),
        .count_o (fifo_count)
    );

    assign pop = head_valid && m_axis.m_tready && !flush_i;

    assign frame_end = (frame_idx_q == FRAME_W'(FRAME_LEN - 1));

    always_comb begin
        frame_idx_d = frame_idx_q;
        if (flush_i)  frame_idx_d = '0;
        else if (pop) frame_idx_d = frame_end ? '0 : frame_idx_q + FRAME_W'(1);
    end

    always_ff @(posedge core_clk) begin
        if (!core_rst_n) frame_idx_q <= '0;
        else             frame_idx_q <= frame_idx_d;
    end

    // The head data is gated so that the bus reads zero whenever nothing is buffered.
    assign m_axis.m_tvalid = head_valid;
    assign m_axis.m_tdata  = head_valid ? head_data : '0;
    assign m_axis.m_tlast  = head_valid && frame_end;

`ifdef BEAM_OUT_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (accept)
            sat_cnt_d = sat_add16(sat_cnt_q, {1'b0, re_rs[OUT_WIDTH]} + {1'b0, im_rs[OUT_WIDTH]});
    end

    always_ff @(posedge core_clk) begin
        if (!core_rst_n) sat_cnt_q <= '0;
        else             sat_cnt_q <= sat_cnt_d;
    end

    assign sat_field = sat_cnt_q;
`else
    logic sat_unused;
    assign sat_unused = re_rs[OUT_WIDTH] ^ im_rs[OUT_WIDTH];
    assign sat_field  = '0;
`endif

    always_comb begin
        status_o = '0;
        status_o[ST_SAT_LSB   +: 16] = sat_field;
        status_o[ST_LEVEL_LSB +: 4]  = 4'(fifo_count);
        status_o[ST_FRAME_LSB +: 8]  = 8'(frame_idx_q);
    end
endmodule

// File: tb/tb_beam_output_formatter.sv
// Testbench for beam_output_formatter (SHIFT=8, OUT_WIDTH=16, FIFO_DEPTH=8, FRAME_LEN=4).
// The reference model keeps a queue of expected words and computes rounding with
// integer floor division. It also tracks frame position and saturation totals.
module tb_beam_output_formatter;
    localparam int OUT_W = 16;
    localparam int DEPTH = 8;
    localparam int FLEN  = 4;

    logic        core_clk = 1'b0;
    logic        core_rst_n = 1'b0;
    logic [31:0] beam_real_i = '0;
    logic [31:0] beam_imag_i = '0;
    logic        beam_valid_i = 1'b0;
    logic        beam_ready_o;
    logic        flush_i = 1'b0;
    logic [31:0] status_o;

    beam_output_formatter_if #(.OUT_WIDTH(OUT_W)) m_if();

    beam_output_formatter #(
        .ACC_WIDTH  (32),
        .OUT_WIDTH  (OUT_W),
        .SHIFT      (8),
        .FIFO_DEPTH (DEPTH),
        .FRAME_LEN  (FLEN)
    ) dut (
        .core_clk     (core_clk),
        .core_rst_n   (core_rst_n),
        .beam_real_i  (beam_real_i),
        .beam_imag_i  (beam_imag_i),
        .beam_valid_i (beam_valid_i),
        .beam_ready_o (beam_ready_o),
        .flush_i      (flush_i),
        .m_axis       (m_if),
        .status_o     (status_o)
    );

    always #5 core_clk = ~core_clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] exp_q[$];
    int          frame_m = 0;
    int          sat_m = 0;

    // per-cycle observations filled in by tick
    logic        obs_acc, obs_hs, obs_last, obs_ready;
    logic [31:0] obs_data;
    logic        exp_ok, exp_last;
    logic [31:0] exp_data;

    // Round half up at a scale of 1/256 using floor division, then clamp to int16.
    function automatic logic [16:0] ref_round(input longint x);
        longint t, y;
        t = x + 128;
        if (t >= 0) y = t / 256;
        else        y = -((-t + 255) / 256);
        if (y > 32767)  return {1'b1, 16'h7FFF};
        if (y < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(y)};
    endfunction

    function automatic int exp_sat();
`ifdef BEAM_OUT_SAT_CNT_EN
        return sat_m;
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] rnd_val();
        logic signed [31:0] s;
        s = $urandom;
        s = s >>> $urandom_range(0, 24);
        return s;
    endfunction

    // Drives one cycle starting just after a falling edge, records what happens at the next
    // rising edge, advances the model, and returns at the following falling edge.
    task automatic tick(input logic v, input logic [31:0] re, input logic [31:0] im,
                        input logic rdy, input logic fl);
        logic [16:0] ri, rq;
        beam_valid_i  = v;
        beam_real_i   = re;
        beam_imag_i   = im;
        m_if.m_tready = rdy;
        flush_i       = fl;
        #1;
        obs_ready = beam_ready_o;
        obs_acc   = v && beam_ready_o;
        obs_hs    = m_if.m_tvalid && rdy && !fl && core_rst_n;
        obs_data  = m_if.m_tdata;
        obs_last  = m_if.m_tlast;
        exp_ok    = 1'b0;
        exp_last  = 1'b0;
        exp_data  = '0;
        if (!core_rst_n) begin
            exp_q.delete();
            frame_m = 0;
            sat_m   = 0;
        end else if (fl) begin
            exp_q.delete();
            frame_m = 0;
        end else begin
            if (obs_hs) begin
                if (exp_q.size() > 0) begin
                    exp_ok   = 1'b1;
                    exp_data = exp_q.pop_front();
                end
                exp_last = (frame_m == FLEN - 1);
                frame_m  = (frame_m + 1) % FLEN;
            end
            if (obs_acc) begin
                ri = ref_round(longint'($signed(re)));
                rq = ref_round(longint'($signed(im)));
                exp_q.push_back({rq[15:0], ri[15:0]});
                sat_m = sat_m + int'(ri[16]) + int'(rq[16]);
                if (sat_m > 65535) sat_m = 65535;
            end
        end
        @(negedge core_clk);
    endtask

    task automatic test_reset();
        core_rst_n = 1'b0;
        tick(1'b1, rnd_val(), rnd_val(), 1'b1, 1'b0);
        tick(1'b1, rnd_val(), rnd_val(), 1'b1, 1'b0);
        checks++; if (m_if.m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_if.m_tvalid); end
        checks++; if (m_if.m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_if.m_tlast); end
        checks++; if (m_if.m_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_if.m_tdata); end
        checks++; if (status_o !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", status_o); end
        checks++; if (beam_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", beam_ready_o); end
        core_rst_n = 1'b1;
        #1;
        checks++; if (beam_ready_o !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", beam_ready_o); end
    endtask

    task automatic test_rounding();
        logic [31:0] vre [6];
        logic [31:0] vim [6];
        logic [31:0] want [6];
        vre[0] = 32'd384;      vim[0] = -32'sd384;      want[0] = 32'hFFFF0002;
        vre[1] = 32'd127;      vim[1] = 32'd0;          want[1] = 32'h00000000;
        vre[2] = 32'd128;      vim[2] = 32'd0;          want[2] = 32'h00000001;
        vre[3] = -32'sd129;    vim[3] = 32'd0;          want[3] = 32'h0000FFFF;
        vre[4] = 32'd8388352;  vim[4] = -32'sd8388480;  want[4] = 32'h80017FFF;
        vre[5] = 32'd8388608;  vim[5] = -32'sd16777216; want[5] = 32'h80007FFF;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, vre[i], vim[i], 1'b0, 1'b0);
            checks++; if (m_if.m_tvalid !== 1'b0) begin errors++; $display("FAIL latency_early[%0d] got %b want 0", i, m_if.m_tvalid); end
            tick(1'b0, '0, '0, 1'b0, 1'b0);
            checks++; if (m_if.m_tvalid !== 1'b1) begin errors++; $display("FAIL latency_n2[%0d] got %b want 1", i, m_if.m_tvalid); end
            checks++; if (m_if.m_tdata !== want[i]) begin errors++; $display("FAIL round[%0d] got %h want %h", i, m_if.m_tdata, want[i]); end
            tick(1'b0, '0, '0, 1'b1, 1'b0);
            checks++; if (!obs_hs || !exp_ok || obs_data !== exp_data) begin errors++; $display("FAIL round_model[%0d] got %h want %h", i, obs_data, exp_data); end
        end
`ifdef BEAM_OUT_SAT_CNT_EN
        checks++; if (status_o[31:16] !== 16'd2) begin errors++; $display("FAIL sat_count got %0d want 2", status_o[31:16]); end
`else
        checks++; if (status_o[31:16] !== 16'd0) begin errors++; $display("FAIL sat_count got %0d want 0", status_o[31:16]); end
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] sre [20];
        logic [31:0] sim [20];
        int k = 0;
        int outs = 0;
        for (int i = 0; i < 20; i++) begin sre[i] = rnd_val(); sim[i] = rnd_val(); end
        for (int c = 0; c < 30; c++) begin
            tick(k < 20, sre[k % 20], sim[k % 20], 1'b0, 1'b0);
            if (obs_acc) k++;
        end
        checks++; if (k !== DEPTH) begin errors++; $display("FAIL bp_accepts got %0d want %0d", k, DEPTH); end
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", obs_ready); end
        checks++; if (status_o[11:8] !== 4'(DEPTH)) begin errors++; $display("FAIL bp_level got %0d want %0d", status_o[11:8], DEPTH); end
        for (int c = 0; c < 200 && outs < 20; c++) begin
            tick(k < 20, sre[k % 20], sim[k % 20], 1'b1, 1'b0);
            if (obs_acc) k++;
            if (obs_hs) begin
                checks++; if (!exp_ok || obs_data !== exp_data) begin errors++; $display("FAIL bp_data[%0d] got %h want %h", outs, obs_data, exp_data); end
                outs++;
            end
        end
        checks++; if (outs !== 20) begin errors++; $display("FAIL bp_count got %0d want 20", outs); end
    endtask

    task automatic test_frame();
        int k = 0;
        int outs = 0;
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        for (int c = 0; c < 100 && outs < 10; c++) begin
            tick(k < 10, rnd_val(), rnd_val(), 1'b1, 1'b0);
            if (obs_acc) k++;
            if (obs_hs) begin
                checks++; if (!exp_ok || obs_data !== exp_data) begin errors++; $display("FAIL frame_data[%0d] got %h want %h", outs, obs_data, exp_data); end
                checks++; if (obs_last !== (outs == 3 || outs == 7)) begin errors++; $display("FAIL frame_tlast[%0d] got %b want %b", outs, obs_last, (outs == 3 || outs == 7)); end
                outs++;
            end
        end
        checks++; if (outs !== 10) begin errors++; $display("FAIL frame_count got %0d want 10", outs); end
        checks++; if (status_o[7:0] !== 8'd2) begin errors++; $display("FAIL frame_idx_end got %0d want 2", status_o[7:0]); end
    endtask

    task automatic test_flush();
        int k = 0;
        for (int c = 0; c < 40 && k < 5; c++) begin
            tick(1'b1, rnd_val(), rnd_val(), 1'b0, 1'b0);
            if (obs_acc) k++;
        end
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        checks++; if (status_o[11:8] !== 4'd5) begin errors++; $display("FAIL flush_level_before got %0d want 5", status_o[11:8]); end
        tick(1'b1, rnd_val(), rnd_val(), 1'b1, 1'b1);
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", obs_ready); end
        checks++; if (m_if.m_tvalid !== 1'b0) begin errors++; $display("FAIL flush_tvalid got %b want 0", m_if.m_tvalid); end
        checks++; if (status_o[7:0] !== 8'd0) begin errors++; $display("FAIL flush_frame_idx got %0d want 0", status_o[7:0]); end
        checks++; if (status_o[11:8] !== 4'd0) begin errors++; $display("FAIL flush_level got %0d want 0", status_o[11:8]); end
        tick(1'b0, '0, '0, 1'b1, 1'b0);
        tick(1'b0, '0, '0, 1'b1, 1'b0);
        tick(1'b0, '0, '0, 1'b1, 1'b0);
        checks++; if (m_if.m_tvalid !== 1'b0) begin errors++; $display("FAIL flush_dropped got %b want 0", m_if.m_tvalid); end
    endtask

    task automatic test_random();
        logic v, r, f;
        for (int c = 0; c < 440; c++) begin
            v = (c < 400) && ($urandom_range(0, 3) != 0);
            r = (c >= 400) || ($urandom_range(0, 3) != 0);
            f = (c < 400) && ($urandom_range(0, 39) == 0);
            tick(v, rnd_val(), rnd_val(), r, f);
            if (obs_hs) begin
                checks++; if (!exp_ok || obs_data !== exp_data) begin errors++; $display("FAIL rand_data[c%0d] got %h want %h", c, obs_data, exp_data); end
                checks++; if (obs_last !== exp_last) begin errors++; $display("FAIL rand_tlast[c%0d] got %b want %b", c, obs_last, exp_last); end
            end
        end
        checks++; if (exp_q.size() != 0 || m_if.m_tvalid !== 1'b0) begin errors++; $display("FAIL rand_drain got %0d left want 0", exp_q.size()); end
        checks++; if (status_o[7:0] !== 8'(frame_m)) begin errors++; $display("FAIL rand_frame_idx got %0d want %0d", status_o[7:0], frame_m); end
        checks++; if (status_o[31:16] !== 16'(exp_sat())) begin errors++; $display("FAIL rand_sat got %0d want %0d", status_o[31:16], exp_sat()); end
    endtask

    task automatic test_reset_midstream();
        int outs = 0;
        for (int c = 0; c < 6; c++) tick(1'b1, rnd_val(), rnd_val(), 1'b0, 1'b0);
        core_rst_n = 1'b0;
        tick(1'b1, rnd_val(), rnd_val(), 1'b1, 1'b0);
        checks++; if (m_if.m_tvalid !== 1'b0 || m_if.m_tlast !== 1'b0 || m_if.m_tdata !== 32'h0) begin errors++; $display("FAIL midrst_outputs got %b/%b/%h want 0/0/0", m_if.m_tvalid, m_if.m_tlast, m_if.m_tdata); end
        checks++; if (status_o !== 32'h0) begin errors++; $display("FAIL midrst_status got %h want 0", status_o); end
        checks++; if (beam_ready_o !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", beam_ready_o); end
        core_rst_n = 1'b1;
        tick(1'b1, 32'd1000, -32'sd1000, 1'b1, 1'b0);
        for (int c = 0; c < 10 && outs == 0; c++) begin
            tick(1'b0, '0, '0, 1'b1, 1'b0);
            if (obs_hs) begin
                outs++;
                checks++; if (!exp_ok || obs_data !== exp_data || obs_data !== 32'hFFFC0004) begin errors++; $display("FAIL midrst_data got %h want %h", obs_data, 32'hFFFC0004); end
                checks++; if (obs_last !== 1'b0) begin errors++; $display("FAIL midrst_tlast got %b want 0", obs_last); end
            end
        end
        checks++; if (outs !== 1 || status_o[7:0] !== 8'd1) begin errors++; $display("FAIL midrst_frame got outs %0d idx %0d want 1 1", outs, status_o[7:0]); end
    endtask

    initial begin
        m_if.m_tready = 1'b0;
        @(negedge core_clk);
        test_reset();
        test_rounding();
        test_backpressure();
        test_frame();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
